radix2_bfly_pipe: RTL and testbench

- Pipelined, parametrised radix-2 decimation-in-time butterfly for the FFT datapath.
- Computes OUT0 = A + B·W and OUT1 = A − B·W on complex operands, where W is a per-transaction complex twiddle.
- Adds valid/ready flow control, an optional per-transaction divide-by-2 scaling mode, and saturation with a sticky overflow flag.
- Drop-in per-stage engine for the FFT/IFFT stage controllers.

---
 rtl/radix2_bfly_pipe.sv | 250 +++++++++++++++++++++++++
 tb/tb_radix2_bfly_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/radix2_bfly_pipe.sv
// Four-stage radix-2 DIT butterfly: OUT0 = A + B*W, OUT1 = A - B*W on complex operands,
// with valid/ready flow control, optional rounded divide-by-2, saturation and a sticky OVF.
module radix2_bfly_pipe #(
    parameter int unsigned DW = 33,
    parameter int unsigned TW = 18
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic                 IN_SCALE,
    input  logic signed [DW-1:0] IN0_RE,
    input  logic signed [DW-1:0] IN0_IM,
    input  logic signed [DW-1:0] IN1_RE,
    input  logic signed [DW-1:0] IN1_IM,
    input  logic signed [TW-1:0] TW_RE,
    input  logic signed [TW-1:0] TW_IM,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic signed [DW-1:0] OUT0_RE,
    output logic signed [DW-1:0] OUT0_IM,
    output logic signed [DW-1:0] OUT1_RE,
    output logic signed [DW-1:0] OUT1_IM,
    output logic                 OVF,
    input  logic                 CLR_OVF
);

    localparam int unsigned PW = DW + TW;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned RW = DW + 2;

    localparam logic signed [SW-1:0] RndC = SW'(1) <<< (TW - 3);
    localparam logic signed [RW-1:0] MaxV = {3'b000, {(DW - 1){1'b1}}};
    localparam logic signed [RW-1:0] MinV = {3'b111, {(DW - 1){1'b0}}};

    function automatic logic signed [PW-1:0] mul(input logic signed [DW-1:0] x,
                                                  input logic signed [TW-1:0] y);
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] ye;
        xe = PW'(x);
        ye = PW'(y);
        return xe * ye;
    endfunction

    // Sum/difference of two products, rounded half-up back to data scale.
    function automatic logic signed [RW-1:0] round_sum(input logic signed [PW-1:0] x,
                                                        input logic signed [PW-1:0] y,
                                                        input logic             sub);
        logic signed [SW-1:0] acc;
        acc = sub ? (SW'(x) - SW'(y)) : (SW'(x) + SW'(y));
        acc = (acc + RndC) >>> (TW - 2);
        return RW'(acc);
    endfunction

    function automatic void scale_sat(input  logic signed [RW-1:0] s,
                                      input  logic                 scale,
                                      output logic signed [DW-1:0] r,
                                      output logic                 sat);
        logic signed [RW-1:0] v;
        v   = scale ? ((s + RW'(1)) >>> 1) : s;
        sat = 1'b0;
        if (v > MaxV) begin
            r   = DW'(MaxV);
            sat = 1'b1;
        end else if (v < MinV) begin
            r   = DW'(MinV);
            sat = 1'b1;
        end else begin
            r = DW'(v);
        end
    endfunction

    logic en;

    // Stage 1: operand capture
    logic                 v1_q, v1_d, sc1_q, sc1_d;
    logic signed [DW-1:0] a1_re_q, a1_re_d, a1_im_q, a1_im_d;
    logic signed [DW-1:0] b1_re_q, b1_re_d, b1_im_q, b1_im_d;
    logic signed [TW-1:0] w1_re_q, w1_re_d, w1_im_q, w1_im_d;

    // Stage 2: partial products
    logic                 v2_q, v2_d, sc2_q, sc2_d;
    logic signed [DW-1:0] a2_re_q, a2_re_d, a2_im_q, a2_im_d;
    logic signed [PW-1:0] p_rr_q, p_rr_d, p_ii_q, p_ii_d, p_ri_q, p_ri_d, p_ir_q, p_ir_d;

    // Stage 3: rounded complex product t = B*W
    logic                 v3_q, v3_d, sc3_q, sc3_d;
    logic signed [DW-1:0] a3_re_q, a3_re_d, a3_im_q, a3_im_d;
    logic signed [RW-1:0] t_re_q, t_re_d, t_im_q, t_im_d;

    // Stage 4: output register
    logic                 out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic signed [DW-1:0] out0_re_q, out0_re_d, out0_im_q, out0_im_d;
    logic signed [DW-1:0] out1_re_q, out1_re_d, out1_im_q, out1_im_d;

    logic signed [RW-1:0] s0_re, s0_im, s1_re, s1_im;
    logic signed [DW-1:0] r0_re, r0_im, r1_re, r1_im;
    logic                 sat0_re, sat0_im, sat1_re, sat1_im;

    assign en       = !out_valid_q || OUT_READY;
    assign IN_READY = en || RST_X;

    always_comb begin
        v1_d    = v1_q;
        sc1_d   = sc1_q;
        a1_re_d = a1_re_q;
        a1_im_d = a1_im_q;
        b1_re_d = b1_re_q;
        b1_im_d = b1_im_q;
        w1_re_d = w1_re_q;
        w1_im_d = w1_im_q;
        if (en) begin
            v1_d    = IN_VALID;
            sc1_d   = IN_SCALE;
            a1_re_d = IN0_RE;
            a1_im_d = IN0_IM;
            b1_re_d = IN1_RE;
            b1_im_d = IN1_IM;
            w1_re_d = TW_RE;
            w1_im_d = TW_IM;
        end
    end

    always_comb begin
        v2_d    = v2_q;
        sc2_d   = sc2_q;
        a2_re_d = a2_re_q;
        a2_im_d = a2_im_q;
        p_rr_d  = p_rr_q;
        p_ii_d  = p_ii_q;
        p_ri_d  = p_ri_q;
        p_ir_d  = p_ir_q;
        if (en) begin
            v2_d    = v1_q;
            sc2_d   = sc1_q;
            a2_re_d = a1_re_q;
            a2_im_d = a1_im_q;
            p_rr_d  = mul(b1_re_q, w1_re_q);
            p_ii_d  = mul(b1_im_q, w1_im_q);
            p_ri_d  = mul(b1_re_q, w1_im_q);
            p_ir_d  = mul(b1_im_q, w1_re_q);
        end
    end

    always_comb begin
        v3_d    = v3_q;
        sc3_d   = sc3_q;
        a3_re_d = a3_re_q;
        a3_im_d = a3_im_q;
        t_re_d  = t_re_q;
        t_im_d  = t_im_q;
        if (en) begin
            v3_d    = v2_q;
            sc3_d   = sc2_q;
            a3_re_d = a2_re_q;
            a3_im_d = a2_im_q;
            t_re_d  = round_sum(p_rr_q, p_ii_q, 1'b1);
            t_im_d  = round_sum(p_ri_q, p_ir_q, 1'b0);
        end
    end

    always_comb begin
        s0_re = RW'(a3_re_q) + t_re_q;
        s0_im = RW'(a3_im_q) + t_im_q;
        s1_re = RW'(a3_re_q) - t_re_q;
        s1_im = RW'(a3_im_q) - t_im_q;
        scale_sat(s0_re, sc3_q, r0_re, sat0_re);
        scale_sat(s0_im, sc3_q, r0_im, sat0_im);
        scale_sat(s1_re, sc3_q, r1_re, sat1_re);
        scale_sat(s1_im, sc3_q, r1_im, sat1_im);

        out_valid_d = out_valid_q;
        out0_re_d   = out0_re_q;
        out0_im_d   = out0_im_q;
        out1_re_d   = out1_re_q;
        out1_im_d   = out1_im_q;
        ovf_d       = ovf_q;
        if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
        if (en) begin
            out_valid_d = v3_q;
            if (v3_q) begin
                out0_re_d = r0_re;
                out0_im_d = r0_im;
                out1_re_d = r1_re;
                out1_im_d = r1_im;
                // A new saturation event overrides a simultaneous clear.
                if (sat0_re || sat0_im || sat1_re || sat1_im) begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_X) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            out0_re_q   <= '0;
            out0_im_q   <= '0;
            out1_re_q   <= '0;
            out1_im_q   <= '0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            v3_q        <= v3_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            out0_re_q   <= out0_re_d;
            out0_im_q   <= out0_im_d;
            out1_re_q   <= out1_re_d;
            out1_im_q   <= out1_im_d;
        end
    end

    // Datapath registers carry no reset; their contents are qualified by the valid bits.
    always_ff @(posedge CLK) begin
        sc1_q   <= sc1_d;
        a1_re_q <= a1_re_d;
        a1_im_q <= a1_im_d;
        b1_re_q <= b1_re_d;
        b1_im_q <= b1_im_d;
        w1_re_q <= w1_re_d;
        w1_im_q <= w1_im_d;
        sc2_q   <= sc2_d;
        a2_re_q <= a2_re_d;
        a2_im_q <= a2_im_d;
        p_rr_q  <= p_rr_d;
        p_ii_q  <= p_ii_d;
        p_ri_q  <= p_ri_d;
        p_ir_q  <= p_ir_d;
        sc3_q   <= sc3_d;
        a3_re_q <= a3_re_d;
        a3_im_q <= a3_im_d;
        t_re_q  <= t_re_d;
        t_im_q  <= t_im_d;
    end

    assign OUT_VALID = out_valid_q;
    assign OUT0_RE   = out0_re_q;
    assign OUT0_IM   = out0_im_q;
    assign OUT1_RE   = out1_re_q;
    assign OUT1_IM   = out1_im_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_radix2_bfly_pipe.sv
// Directed bench for radix2_bfly_pipe: hand-computed vectors, a queue of expected results
// checked at every output handshake, plus latency, hold, backpressure and reset scenarios.
module tb_radix2_bfly_pipe;

    localparam int DW = 33;
    localparam int TW = 18;

    typedef logic signed [DW-1:0] d_t;
    typedef logic signed [TW-1:0] w_t;
    typedef struct {
        longint o0r;
        longint o0i;
        longint o1r;
        longint o1i;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_X, IN_VALID, IN_READY, IN_SCALE, OUT_VALID, OUT_READY, OVF, CLR_OVF;
    d_t   IN0_RE, IN0_IM, IN1_RE, IN1_IM;
    w_t   TW_RE, TW_IM;
    d_t   OUT0_RE, OUT0_IM, OUT1_RE, OUT1_IM;

    int   checks = 0;
    int   errors = 0;
    int   rx_cnt = 0;
    exp_t exp_q[$];

    logic hold_q = 1'b0;
    d_t   h0r, h0i, h1r, h1i;

    always #5 CLK = ~CLK;

    radix2_bfly_pipe #(.DW(DW), .TW(TW)) u_dut (
        .CLK      (CLK),
        .RST_X    (RST_X),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .IN_SCALE (IN_SCALE),
        .IN0_RE   (IN0_RE),
        .IN0_IM   (IN0_IM),
        .IN1_RE   (IN1_RE),
        .IN1_IM   (IN1_IM),
        .TW_RE    (TW_RE),
        .TW_IM    (TW_IM),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OUT0_RE  (OUT0_RE),
        .OUT0_IM  (OUT0_IM),
        .OUT1_RE  (OUT1_RE),
        .OUT1_IM  (OUT1_IM),
        .OVF      (OVF),
        .CLR_OVF  (CLR_OVF)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every handshake pops one expected result; stalled outputs must not move.
    always @(negedge CLK) begin
        if (!RST_X) begin
            if (hold_q) begin
                check_eq("hold_o0r", longint'(OUT0_RE), longint'(h0r));
                check_eq("hold_o0i", longint'(OUT0_IM), longint'(h0i));
                check_eq("hold_o1r", longint'(OUT1_RE), longint'(h1r));
                check_eq("hold_o1i", longint'(OUT1_IM), longint'(h1i));
            end
            hold_q <= OUT_VALID && !OUT_READY;
            h0r    <= OUT0_RE;
            h0i    <= OUT0_IM;
            h1r    <= OUT1_RE;
            h1i    <= OUT1_IM;
            if (OUT_VALID && OUT_READY) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", longint'(OUT_VALID), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("out0_re", longint'(OUT0_RE), e.o0r);
                    check_eq("out0_im", longint'(OUT0_IM), e.o0i);
                    check_eq("out1_re", longint'(OUT1_RE), e.o1r);
                    check_eq("out1_im", longint'(OUT1_IM), e.o1i);
                    rx_cnt <= rx_cnt + 1;
                end
            end
        end else begin
            hold_q <= 1'b0;
        end
    end

    task automatic drive(input longint ar, input longint ai, input longint br, input longint bi,
                         input longint wr, input longint wi, input logic sc);
        IN0_RE   = d_t'(ar);
        IN0_IM   = d_t'(ai);
        IN1_RE   = d_t'(br);
        IN1_IM   = d_t'(bi);
        TW_RE    = w_t'(wr);
        TW_IM    = w_t'(wi);
        IN_SCALE = sc;
    endtask

    task automatic push_exp(input longint e0r, input longint e0i, input longint e1r,
                            input longint e1i);
        exp_t e;
        e.o0r = e0r;
        e.o0i = e0i;
        e.o1r = e1r;
        e.o1i = e1i;
        exp_q.push_back(e);
    endtask

    // One isolated transaction on an idle pipeline; checks latency and OVF on arrival.
    task automatic run_one(input string tag, input longint ar, input longint ai,
                           input longint br, input longint bi, input longint wr,
                           input longint wi, input logic sc, input longint e0r,
                           input longint e0i, input longint e1r, input longint e1i,
                           input logic eovf);
        int lat;
        push_exp(e0r, e0i, e1r, e1i);
        drive(ar, ai, br, bi, wr, wi, sc);
        IN_VALID = 1'b1;
        @(negedge CLK);
        check_eq({tag, "_rdy"}, longint'(IN_READY), 1);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        lat = 1;
        while (!OUT_VALID && lat < 12) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check_eq({tag, "_lat"}, longint'(lat), 4);
        check_eq({tag, "_ovf"}, longint'(OVF), longint'(eovf));
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int rx0;
        RST_X     = 1'b1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        CLR_OVF   = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1'b0);
        @(negedge CLK);
        check_eq("rst_in_ready", longint'(IN_READY), 1);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_X = 1'b0;
        check_eq("rst_out_valid", longint'(OUT_VALID), 0);
        check_eq("rst_ovf", longint'(OVF), 0);
        check_eq("rst_out0_re", longint'(OUT0_RE), 0);
        check_eq("rst_out1_im", longint'(OUT1_IM), 0);

        run_one("ident", 100, 20, 30, -10, 65536, 0, 1'b0, 130, 10, 70, 30, 1'b0);
        run_one("minus_j", 100, 20, 30, -10, 0, -65536, 1'b0, 90, -10, 110, 50, 1'b0);
        run_one("half_w", 0, 0, 1, -1, 32768, 0, 1'b0, 1, 0, -1, 0, 1'b0);
        run_one("cplx_w", 10, 10, 3, 1, 32768, 32768, 1'b0, 11, 12, 9, 8, 1'b0);
        run_one("scl_p3", 3, 0, 0, 0, 65536, 0, 1'b1, 2, 0, 2, 0, 1'b0);
        run_one("scl_m3", -3, 0, 0, 0, 65536, 0, 1'b1, -1, 0, -1, 0, 1'b0);
        run_one("scl_5", 5, -5, 0, 0, 65536, 0, 1'b1, 3, -2, 3, -2, 1'b0);

        run_one("sat_pos", 64'sd4294967295, 0, 64'sd4294967295, 0, 65536, 0, 1'b0,
                64'sd4294967295, 0, 0, 0, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        check_eq("ovf_sticky", longint'(OVF), 1);
        CLR_OVF = 1'b1;
        @(posedge CLK);
        #1;
        CLR_OVF = 1'b0;
        check_eq("ovf_clr", longint'(OVF), 0);
        run_one("sat_scl", 64'sd4294967295, 0, 64'sd4294967295, 0, 65536, 0, 1'b1,
                64'sd4294967295, 0, 0, 0, 1'b0);
        run_one("sat_neg", -64'sd4294967296, 0, -64'sd4294967296, 0, 65536, 0, 1'b0,
                -64'sd4294967296, 0, 0, 0, 1'b1);
        CLR_OVF = 1'b1;
        @(posedge CLK);
        #1;
        CLR_OVF = 1'b0;
        check_eq("ovf_clr2", longint'(OVF), 0);

        // Back-to-back stream with a three-cycle downstream stall.
        rx0 = rx_cnt;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    int   tries;
                    logic acc;
                    drive(10 * i, -i, i, 2, 65536, 0, 1'b0);
                    IN_VALID = 1'b1;
                    push_exp(11 * i, 2 - i, 9 * i, -i - 2);
                    tries = 0;
                    acc   = 1'b0;
                    while (!acc && tries < 20) begin
                        @(negedge CLK);
                        acc = IN_READY;
                        @(posedge CLK);
                        #1;
                        tries++;
                    end
                    check_eq("stream_acc", longint'(acc), 1);
                end
                IN_VALID = 1'b0;
            end
            begin
                repeat (7) @(posedge CLK);
                #1;
                OUT_READY = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge CLK);
                    check_eq("stall_vld", longint'(OUT_VALID), 1);
                    check_eq("stall_rdy", longint'(IN_READY), 0);
                    @(posedge CLK);
                    #1;
                end
                OUT_READY = 1'b1;
            end
        join
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge CLK);
            #1;
        end
        @(posedge CLK);
        #1;
        check_eq("stream_left", longint'(exp_q.size()), 0);
        check_eq("stream_rx", longint'(rx_cnt - rx0), 10);

        // Three transactions in flight, then a one-cycle reset flushes them.
        for (int i = 0; i < 3; i++) begin
            drive(7 + i, 1, 2, 3, 65536, 0, 1'b0);
            IN_VALID = 1'b1;
            @(posedge CLK);
            #1;
        end
        IN_VALID = 1'b0;
        RST_X    = 1'b1;
        @(posedge CLK);
        #1;
        RST_X = 1'b0;
        check_eq("rst_mid_o0r", longint'(OUT0_RE), 0);
        for (int k = 0; k < 6; k++) begin
            check_eq("rst_flush", longint'(OUT_VALID), 0);
            @(posedge CLK);
            #1;
        end
        run_one("post_rst", 100, 20, 30, -10, 65536, 0, 1'b0, 130, 10, 70, 30, 1'b0);

        check_eq("final_left", longint'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
